// File: rtl/sum_diff_pkg.sv
// -----------------------------------------------------------------------------
// sum_diff_pkg
// Shared types and helpers for the (A+B)-(C+D) accumulate datapath.
//   state_t    : group FSM state (IDLE = no open group, ACC = group open)
//   res_width(): result width for a given operand width and group depth
//   WIDTH_DEF / ACC_DEPTH_DEF : default parameter values
// -----------------------------------------------------------------------------
package sum_diff_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam int WIDTH_DEF     = 4;
  localparam int ACC_DEPTH_DEF = 4;

  // WIDTH+1 bits per pair sum, +1 for the signed difference, and
  // log2(depth) bits of growth from summing depth differences.
  function automatic int res_width(input int width, input int depth);
    return width + 2 + $clog2(depth);
  endfunction

endpackage

// File: rtl/sum_diff_accum_pair_adder.sv
// -----------------------------------------------------------------------------
// pair_adder
// Combinational unsigned adder with full carry-out.
//   x, y : WIDTH-bit unsigned operands
//   sum  : WIDTH+1-bit unsigned sum (never wraps)
// -----------------------------------------------------------------------------
module pair_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/sum_diff_accum.sv
// -----------------------------------------------------------------------------
// sum_diff_accum
// Two-stage pipelined F = (a+b)-(c+d) with optional accumulation of
// ACC_DEPTH consecutive results into one output. Ready/valid on both sides.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready is combinational)
//   a, b, c, d        : WIDTH-bit unsigned operands
//   mode              : 0 = single result, 1 = open an accumulate group
//   out_valid/out_ready : result handshake
//   f                 : RES_W-bit signed result
//   busy              : an accumulate group is open
// -----------------------------------------------------------------------------
module sum_diff_accum
  import sum_diff_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int ACC_DEPTH = ACC_DEPTH_DEF,
  localparam int RES_W     = res_width(WIDTH, ACC_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [WIDTH-1:0]        c,
  input  logic [WIDTH-1:0]        d,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [RES_W-1:0] f,
  output logic                    busy
);

  localparam int               CNT_W    = $clog2(ACC_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_DEPTH - 1);

  // Stage 1 operand-pair sums.
  logic [WIDTH:0] sum_ab;
  logic [WIDTH:0] sum_cd;

  pair_adder #(.WIDTH(WIDTH)) u_add_ab (.x(a), .y(b), .sum(sum_ab));
  pair_adder #(.WIDTH(WIDTH)) u_add_cd (.x(c), .y(d), .sum(sum_cd));

  logic           s1_valid;
  logic           s1_mode;
  logic [WIDTH:0] s1_ab;
  logic [WIDTH:0] s1_cd;

  // Group state and accumulator.
  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic signed [RES_W-1:0] acc, acc_nxt;
  logic signed [RES_W-1:0] res_nxt;
  logic                    load;

  logic                    advance;
  logic signed [WIDTH+1:0] diff;
  logic signed [RES_W-1:0] diff_ext;

  // The whole pipe moves together; it only stalls when a result is
  // sitting in the output register and the consumer refuses it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign busy     = (state == ACC);

  assign diff     = $signed({1'b0, s1_ab}) - $signed({1'b0, s1_cd});
  assign diff_ext = RES_W'(diff);  // signed cast sign-extends

  // NOTE: every output of this block gets a default first so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    res_nxt   = f;
    load      = 1'b0;
    if (advance && s1_valid) begin
      unique case (state)
        IDLE: begin
          if (!s1_mode) begin
            load    = 1'b1;
            res_nxt = diff_ext;
          end else begin
            acc_nxt   = diff_ext;
            cnt_nxt   = CNT_W'(1);
            state_nxt = ACC;
          end
        end
        ACC: begin
          // Inside a group the item's own mode bit is ignored.
          if (cnt == CNT_LAST) begin
            load      = 1'b1;
            res_nxt   = acc + diff_ext;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            acc_nxt = acc + diff_ext;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_ab     <= '0;
      s1_cd     <= '0;
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      f         <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      if (advance) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= mode;
          s1_ab   <= sum_ab;
          s1_cd   <= sum_cd;
        end
        // A consumed result is replaced in the same edge if a new one
        // loads; otherwise out_valid drops and f keeps its last value.
        out_valid <= load;
        if (load) f <= res_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sum_diff_accum.sv
// -----------------------------------------------------------------------------
// tb_sum_diff_accum
// Scoreboard bench for sum_diff_accum (WIDTH=4, ACC_DEPTH=4, RES_W=8).
// Stimulus pushes hand-computed expected results; a monitor pops and
// compares on every accepted output beat.
// -----------------------------------------------------------------------------
module tb_sum_diff_accum;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        a, b, c, d;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] f;
  logic              busy;

  sum_diff_accum #(.WIDTH(4), .ACC_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b, c, d;
    int         f;
  } vec_t;

  vec_t v[5] = '{
    '{4'd11, 4'd12, 4'd9,  4'd7,  7},
    '{4'd14, 4'd14, 4'd13, 4'd11, 4},
    '{4'd14, 4'd8,  4'd0,  4'd8,  14},
    '{4'd15, 4'd15, 4'd9,  4'd11, 10},
    '{4'd5,  4'd14, 4'd1,  4'd3,  15}
  };

  vec_t ext[3] = '{
    '{4'd15, 4'd15, 4'd0,  4'd0,  30},
    '{4'd0,  4'd0,  4'd15, 4'd15, -30},
    '{4'd0,  4'd0,  4'd0,  4'd0,  0}
  };

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int busy_cnt = 0;
  int c0;
  logic fire = 1'b0;

  int exp_q[$];
  int out_cycs[$];

  always @(posedge clk) cyc  <= cyc + 1;
  always @(posedge clk) fire <= in_valid && in_ready;
  always @(negedge clk) if (busy) busy_cnt++;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got f=%0d, expected no output", f);
      end else begin
        check("f", 32'(f), exp_q.pop_front());
      end
    end
  end

  task automatic send(input vec_t x, input logic m);
    int t = 0;
    a = x.a; b = x.b; c = x.c; d = x.d; mode = m;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!fire && t < 50);
    if (!fire) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0; mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_f",         32'(f),         0);
    check("rst_busy",      32'(busy),      0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-mode stream, back to back.
    out_cycs.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(v[i].f);
      send(v[i], 1'b0);
      if (i == 0) c0 = cyc;
    end
    wait_drain();
    check("single_count", out_cycs.size(), 5);
    for (int i = 0; i < 5 && i < out_cycs.size(); i++)
      check("single_cycle", out_cycs[i], c0 + 1 + i);

    // Extremes.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ext[i].f);
      send(ext[i], 1'b0);
    end
    wait_drain();

    // Accumulate groups.
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(35);
      send(v[i], 1'b1);
    end
    wait_drain();
    check("acc_busy_cycles", busy_cnt, 3);
    check("acc_busy_after",  32'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(-120);
      send(ext[1], 1'b1);
    end
    wait_drain();

    // Backpressure: consumer stalls for 3 cycles with a result held.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          exp_q.push_back(v[i].f);
          send(v[i], 1'b0);
        end
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        check("bp_valid", 32'(out_valid), 1);
        repeat (3) begin
          check("bp_f_stable", 32'(f),        7);
          check("bp_in_ready", 32'(in_ready), 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Mixed modes: 1,0,0,0 forms one group, then a lone single item.
    out_cycs.delete();
    send(v[4], 1'b1);
    send(v[0], 1'b0);
    send(v[1], 1'b0);
    exp_q.push_back(40);
    send(v[2], 1'b0);
    exp_q.push_back(10);
    send(v[3], 1'b0);
    wait_drain();
    check("mixed_count", out_cycs.size(), 2);
    if (out_cycs.size() == 2)
      check("mixed_next_cycle", out_cycs[1], out_cycs[0] + 1);

    // Asynchronous reset in the middle of a group with two items absorbed.
    send(v[0], 1'b1);
    send(v[1], 1'b1);
    @(posedge clk); #2;
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("arst_busy",      32'(busy),      0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_f",         32'(f),         0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(35);
      send(v[i], 1'b1);
    end
    wait_drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
